writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_if.sv | 33 +++
 rtl/writeback_arbiter.sv | 102 ++++++++++
 tb/tb_writeback_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : writeback_arbiter_if
// Purpose : Requester/register-file bundle for the writeback arbiter.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface writeback_arbiter_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      o_req_ready;
  logic [NREQ*5-1:0]    i_req_addr;
  logic [NREQ*XLEN-1:0] i_req_data;
  logic                 i_wb_hold;
  logic                 o_rd_wvalid;
  logic [4:0]           o_rd_waddr;
  logic [XLEN-1:0]      o_rd_wdata;
  logic [NREQ-1:0]      o_grant;

  modport master (
    output i_req_valid, i_req_addr, i_req_data, i_wb_hold,
    input  o_req_ready, o_rd_wvalid, o_rd_waddr, o_rd_wdata, o_grant
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_data, i_wb_hold,
    output o_req_ready, o_rd_wvalid, o_rd_waddr, o_rd_wdata, o_grant
  );
endinterface

`default_nettype wire

// File: rtl/writeback_arbiter.sv
//------------------------------------------------------------------------------
// Module  : writeback_arbiter
// Purpose : Round-robin arbiter merging writeback requesters onto one
//           register-file write port, one-cycle registered output.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module writeback_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rstn,
  writeback_arbiter_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [NREQ-1:0]  r_grant;
  logic             r_wvalid;
  logic [4:0]       r_waddr;
  logic [XLEN-1:0]  r_wdata;

  logic [NREQ-1:0]  w_sel_oh;
  logic [PTR_W-1:0] w_sel_idx;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W:0]   w_idx;
  logic             w_xfer;
  logic [4:0]       w_addr;
  logic [XLEN-1:0]  w_data;

  // Scan requesters starting at the pointer; the first valid one wins.
  always_comb begin
    w_sel_oh  = '0;
    w_sel_idx = '0;
    w_xfer    = 1'b0;
    w_idx     = '0;
    if (rstn && !bus.i_wb_hold) begin
      for (int i = 0; i < NREQ; i++) begin
        w_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
        if (w_idx >= (PTR_W+1)'(NREQ))
          w_idx = w_idx - (PTR_W+1)'(NREQ);
        if (!w_xfer && bus.i_req_valid[w_idx[PTR_W-1:0]]) begin
          w_sel_oh[w_idx[PTR_W-1:0]] = 1'b1;
          w_sel_idx                  = w_idx[PTR_W-1:0];
          w_xfer                     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_sel_oh[k]) begin
        w_addr = bus.i_req_addr[5*k +: 5];
        w_data = bus.i_req_data[XLEN*k +: XLEN];
      end
    end
  end

  always_comb begin
    if (w_sel_idx == PTR_W'(NREQ-1))
      w_ptr_nxt = '0;
    else
      w_ptr_nxt = w_sel_idx + PTR_W'(1);
  end

  // Writes to x0 still consume the grant, but never strobe the register file.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr    <= '0;
      r_grant  <= '0;
      r_wvalid <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else if (w_xfer) begin
      r_ptr    <= w_ptr_nxt;
      r_grant  <= w_sel_oh;
      r_wvalid <= |w_addr;
      if (|w_addr) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
    end else begin
      r_wvalid <= 1'b0;
      r_grant  <= '0;
    end
  end

  assign bus.o_req_ready = w_sel_oh;
  assign bus.o_rd_wvalid = r_wvalid;
  assign bus.o_rd_waddr  = r_waddr;
  assign bus.o_rd_wdata  = r_wdata;
  assign bus.o_grant     = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_writeback_arbiter
// Purpose : Directed vector bench for writeback_arbiter.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_writeback_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 3;

  localparam logic [31:0] c_D0 = 32'hDEADBEEF;
  localparam logic [31:0] c_D1 = 32'h1111_0001;
  localparam logic [31:0] c_D2 = 32'h2222_0002;
  localparam logic [14:0] c_ADDRS  = {5'd7, 5'd6, 5'd5};
  localparam logic [14:0] c_ADDRSX = {5'd7, 5'd0, 5'd5};
  localparam logic [95:0] c_DATAS  = {c_D2, c_D1, c_D0};
  localparam logic [95:0] c_DATASX = {c_D2, 32'h0000_1234, c_D0};

  typedef struct {
    logic [2:0]  valid;
    logic        hold;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
    logic        exp_wvalid;
    logic        chk_data;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [2:0]  exp_grant;
  } vec_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  vec_t vecs [16];

  writeback_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  writeback_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic h, input logic [14:0] a, input logic [95:0] d);
    bus.i_req_valid = v;
    bus.i_wb_hold   = h;
    bus.i_req_addr  = a;
    bus.i_req_data  = d;
  endtask

  initial begin
    int last_g2;
    int ngrant2;
    checks = 0;
    errors = 0;

    // Pointer before each row noted on the right.
    vecs[0]  = '{3'b001, 1'b0, c_ADDRS,  c_DATAS,  3'b001, 1'b1, 1'b1, 5'd5, c_D0, 3'b001}; // P0
    vecs[1]  = '{3'b000, 1'b0, c_ADDRS,  c_DATAS,  3'b000, 1'b0, 1'b1, 5'd5, c_D0, 3'b000}; // P1
    vecs[2]  = '{3'b110, 1'b0, c_ADDRSX, c_DATASX, 3'b010, 1'b0, 1'b0, 5'd0, 32'h0, 3'b010}; // P1
    vecs[3]  = '{3'b111, 1'b0, c_ADDRS,  c_DATAS,  3'b100, 1'b1, 1'b1, 5'd7, c_D2, 3'b100}; // P2
    vecs[4]  = '{3'b111, 1'b0, c_ADDRS,  c_DATAS,  3'b001, 1'b1, 1'b1, 5'd5, c_D0, 3'b001}; // P0
    vecs[5]  = '{3'b111, 1'b0, c_ADDRS,  c_DATAS,  3'b010, 1'b1, 1'b1, 5'd6, c_D1, 3'b010}; // P1
    vecs[6]  = '{3'b111, 1'b0, c_ADDRS,  c_DATAS,  3'b100, 1'b1, 1'b1, 5'd7, c_D2, 3'b100}; // P2
    vecs[7]  = '{3'b111, 1'b0, c_ADDRS,  c_DATAS,  3'b001, 1'b1, 1'b1, 5'd5, c_D0, 3'b001}; // P0
    vecs[8]  = '{3'b111, 1'b0, c_ADDRS,  c_DATAS,  3'b010, 1'b1, 1'b1, 5'd6, c_D1, 3'b010}; // P1
    vecs[9]  = '{3'b001, 1'b0, c_ADDRS,  c_DATAS,  3'b001, 1'b1, 1'b1, 5'd5, c_D0, 3'b001}; // P2
    vecs[10] = '{3'b110, 1'b1, c_ADDRS,  c_DATAS,  3'b000, 1'b0, 1'b1, 5'd5, c_D0, 3'b000}; // P1
    vecs[11] = '{3'b110, 1'b1, c_ADDRS,  c_DATAS,  3'b000, 1'b0, 1'b1, 5'd5, c_D0, 3'b000}; // P1
    vecs[12] = '{3'b110, 1'b1, c_ADDRS,  c_DATAS,  3'b000, 1'b0, 1'b1, 5'd5, c_D0, 3'b000}; // P1
    vecs[13] = '{3'b110, 1'b0, c_ADDRS,  c_DATAS,  3'b010, 1'b1, 1'b1, 5'd6, c_D1, 3'b010}; // P1
    vecs[14] = '{3'b011, 1'b0, c_ADDRS,  c_DATAS,  3'b001, 1'b1, 1'b1, 5'd5, c_D0, 3'b001}; // P2
    vecs[15] = '{3'b000, 1'b0, c_ADDRS,  c_DATAS,  3'b000, 1'b0, 1'b1, 5'd5, c_D0, 3'b000}; // P1

    // Reset state, with requests present to show ready is suppressed.
    rstn = 1'b0;
    drive(3'b111, 1'b0, c_ADDRS, c_DATAS);
    #3;
    check("rst ready",  64'(bus.o_req_ready), 64'd0);
    check("rst wvalid", 64'(bus.o_rd_wvalid), 64'd0);
    check("rst waddr",  64'(bus.o_rd_waddr),  64'd0);
    check("rst wdata",  64'(bus.o_rd_wdata),  64'd0);
    check("rst grant",  64'(bus.o_grant),     64'd0);
    drive(3'b000, 1'b0, c_ADDRS, c_DATAS);
    #9 rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].hold, vecs[i].addr, vecs[i].data);
      #1;
      check($sformatf("v%0d ready", i), 64'(bus.o_req_ready), 64'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("v%0d wvalid", i), 64'(bus.o_rd_wvalid), 64'(vecs[i].exp_wvalid));
      check($sformatf("v%0d grant", i),  64'(bus.o_grant),     64'(vecs[i].exp_grant));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d waddr", i), 64'(bus.o_rd_waddr), 64'(vecs[i].exp_waddr));
        check($sformatf("v%0d wdata", i), 64'(bus.o_rd_wdata), 64'(vecs[i].exp_wdata));
      end
    end

    // Asynchronous reset while a write is on the output, then restart from P=0.
    drive(3'b001, 1'b0, c_ADDRS, c_DATAS);
    @(posedge clk); #1;
    check("mid wvalid before", 64'(bus.o_rd_wvalid), 64'd1);
    drive(3'b000, 1'b0, c_ADDRS, c_DATAS);
    #1 rstn = 1'b0;
    #1;
    check("mid wvalid async", 64'(bus.o_rd_wvalid), 64'd0);
    check("mid grant async",  64'(bus.o_grant),     64'd0);
    check("mid waddr async",  64'(bus.o_rd_waddr),  64'd0);
    drive(3'b110, 1'b0, c_ADDRS, c_DATAS);
    #1;
    check("mid ready in rst", 64'(bus.o_req_ready), 64'd0);
    #1 rstn = 1'b1;
    #1;
    check("post rst ready", 64'(bus.o_req_ready), 64'b010);
    @(posedge clk); #1;
    check("post rst grant", 64'(bus.o_grant),    64'b010);
    check("post rst waddr", 64'(bus.o_rd_waddr), 64'd6);
    check("post rst wdata", 64'(bus.o_rd_wdata), 64'(c_D1));

    // Requester 2 always valid, others random: gap between its grants <= NREQ.
    last_g2 = 0;
    ngrant2 = 0;
    for (int c = 1; c <= 1000; c++) begin
      drive({1'b1, 2'($urandom_range(0, 3))}, 1'b0, c_ADDRS, c_DATAS);
      #1;
      if (bus.o_req_ready[2]) begin
        check($sformatf("starve gap c%0d", c), 64'(c - last_g2 <= NREQ), 64'd1);
        last_g2 = c;
        ngrant2++;
      end
      @(posedge clk); #1;
    end
    check("starve tail gap", 64'(1000 - last_g2 < NREQ), 64'd1);
    check("starve any grant", 64'(ngrant2 > 0), 64'd1);
    drive(3'b000, 1'b0, c_ADDRS, c_DATAS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
